// File: rtl/coreaxi4dmacontroller_axi4_lite_pkg.sv
// Shared types and constants for the DMA AXI4-Lite initiator: one-hot FSM
// encoding, AXI response codes and the fixed data/strobe widths.
package coreaxi4dmacontroller_axi4_lite_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        WR_REQ  = 5'b00010,
        WR_RESP = 5'b00100,
        RD_REQ  = 5'b01000,
        RD_RESP = 5'b10000
    } state_t;

endpackage

// File: rtl/coreaxi4dmacontroller_mstr_timeout_cnt.sv
// Watchdog for the AXI4-Lite initiator: counts busy cycles since the last
// command accept and raises a sticky flag. Compiled only with COREAXI4DMA_MSTR_TIMEOUT_EN.
`ifdef COREAXI4DMA_MSTR_TIMEOUT_EN
module coreaxi4dmacontroller_mstr_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLOCK,
    input  logic RESETN,
    input  logic clear,
    input  logic busy,
    output logic timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Counter saturates at the limit so the flag cannot be lost by wrap-around.
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else if (clear) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else if (busy && (count != CW'(TIMEOUT_CYCLES))) begin
            count <= count + CW'(1);
            if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/coreaxi4dmacontroller_axi4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite initiator for the DMA's internal command port.
// Optional watchdog enabled by defining COREAXI4DMA_MSTR_TIMEOUT_EN.
module coreaxi4dmacontroller_axi4_lite_master_ctrl
    import coreaxi4dmacontroller_axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLOCK,
    input  logic                  RESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [1:0]            rsp_resp,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    output logic                  timeout_err
);

    state_t state, state_nxt;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic                  addr_lsb_unused;

    logic                  cmd_ready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                  arvalid_nxt, rready_nxt;
    logic                  rsp_valid_nxt, rsp_write_nxt;
    logic [1:0]            rsp_resp_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt, wdata_nxt;
    logic [STRB_WIDTH-1:0] wstrb_nxt;
    logic [ADDR_WIDTH-1:0] awaddr_nxt, araddr_nxt;

    assign accept          = cmd_valid & cmd_ready;
    assign addr_aligned    = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
    assign addr_lsb_unused = ^cmd_addr[1:0];

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A channel counts as done once its VALID has dropped or is handshaking now.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) state_nxt = WR_RESP;
            WR_RESP: if (BVALID && BREADY) state_nxt = IDLE;
            RD_REQ:  if (ARVALID && ARREADY) state_nxt = RD_RESP;
            RD_RESP: if (RVALID && RREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_nxt = (state_nxt == IDLE);
        bready_nxt    = (state_nxt == WR_RESP);
        rready_nxt    = (state_nxt == RD_RESP);
        awvalid_nxt   = AWVALID;
        wvalid_nxt    = WVALID;
        arvalid_nxt   = ARVALID;
        awaddr_nxt    = AWADDR;
        araddr_nxt    = ARADDR;
        wdata_nxt     = WDATA;
        wstrb_nxt     = WSTRB;
        rsp_valid_nxt = 1'b0;
        rsp_write_nxt = rsp_write;
        rsp_resp_nxt  = rsp_resp;
        rsp_rdata_nxt = rsp_rdata;
        case (state)
            IDLE: begin
                if (accept && cmd_write) begin
                    awvalid_nxt = 1'b1;
                    wvalid_nxt  = 1'b1;
                    awaddr_nxt  = addr_aligned;
                    wdata_nxt   = cmd_wdata;
                    wstrb_nxt   = cmd_wstrb;
                end else if (accept) begin
                    arvalid_nxt = 1'b1;
                    araddr_nxt  = addr_aligned;
                end
            end
            WR_REQ: begin
                if (AWREADY) awvalid_nxt = 1'b0;
                if (WREADY)  wvalid_nxt  = 1'b0;
            end
            WR_RESP: begin
                if (BVALID && BREADY) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b1;
                    rsp_resp_nxt  = BRESP;
                    rsp_rdata_nxt = '0;
                end
            end
            RD_REQ: begin
                if (ARREADY) arvalid_nxt = 1'b0;
            end
            RD_RESP: begin
                if (RVALID && RREADY) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_write_nxt = 1'b0;
                    rsp_resp_nxt  = RRESP;
                    rsp_rdata_nxt = RDATA;
                end
            end
            default: ;
        endcase
    end

    // Every external output is a flop so the fabric sees glitch-free signals.
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            cmd_ready <= 1'b1;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            AWADDR    <= '0;
            ARADDR    <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_resp  <= RESP_OKAY;
            rsp_rdata <= '0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            AWVALID   <= awvalid_nxt;
            WVALID    <= wvalid_nxt;
            BREADY    <= bready_nxt;
            ARVALID   <= arvalid_nxt;
            RREADY    <= rready_nxt;
            AWADDR    <= awaddr_nxt;
            ARADDR    <= araddr_nxt;
            WDATA     <= wdata_nxt;
            WSTRB     <= wstrb_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_write <= rsp_write_nxt;
            rsp_resp  <= rsp_resp_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

`ifdef COREAXI4DMA_MSTR_TIMEOUT_EN
    coreaxi4dmacontroller_mstr_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .CLOCK      (CLOCK),
        .RESETN     (RESETN),
        .clear      (accept),
        .busy       (state != IDLE),
        .timeout_err(timeout_err)
    );
`else
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_coreaxi4dmacontroller_axi4_lite_master_ctrl.sv
// Self-checking bench for the AXI4-Lite initiator: vector table plus hand-written
// corner sequences; watchdog checks depend on COREAXI4DMA_MSTR_TIMEOUT_EN.
module tb_coreaxi4dmacontroller_axi4_lite_master_ctrl;
    import coreaxi4dmacontroller_axi4_lite_pkg::*;

`ifdef COREAXI4DMA_MSTR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESETN = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [10:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [10:0] AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        timeout_err;

    coreaxi4dmacontroller_axi4_lite_master_ctrl #(
        .ADDR_WIDTH(11), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLOCK(CLOCK), .RESETN(RESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
        .rsp_rdata(rsp_rdata),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .timeout_err(timeout_err)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rsp_cyc = -1;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic        write;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          la;
        int          lw;
        int          lr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [10:0] exp_addr;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs[7];

    // slave model configuration
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] r_data = '0;
    bit          stray = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Slave: READY/VALID decided at the falling edge from the DUT's registered outputs.
    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        BRESP = 0; RRESP = 0; RDATA = 0;
        forever begin
            @(negedge CLOCK);
            AWREADY = AWVALID && (aw_cnt >= aw_lat);
            aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
            WREADY  = WVALID && (w_cnt >= w_lat);
            w_cnt   = WVALID ? w_cnt + 1 : 0;
            ARREADY = ARVALID && (ar_cnt >= ar_lat);
            ar_cnt  = ARVALID ? ar_cnt + 1 : 0;
            BVALID  = stray || (BREADY && (b_cnt >= b_lat));
            b_cnt   = BREADY ? b_cnt + 1 : 0;
            RVALID  = stray || (RREADY && (r_cnt >= r_lat));
            r_cnt   = RREADY ? r_cnt + 1 : 0;
            BRESP   = b_resp;
            RRESP   = r_resp;
            RDATA   = r_data;
        end
    end

    // Monitor: response scoreboard and VALID/payload stability while stalled.
    initial begin
        bit aw_pend, w_pend, ar_pend;
        logic [10:0] aw_hold, ar_hold;
        logic [35:0] w_hold;
        rsp_t e;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_hold = '0; ar_hold = '0; w_hold = '0;
        forever begin
            @(negedge CLOCK);
            #2;
            if (!RESETN) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_pend) check("aw_stable", {AWVALID, AWADDR}, {1'b1, aw_hold});
                if (w_pend)  check("w_stable", {WVALID, WSTRB, WDATA}, {1'b1, w_hold});
                if (ar_pend) check("ar_stable", {ARVALID, ARADDR}, {1'b1, ar_hold});
                aw_pend = AWVALID && !AWREADY; aw_hold = AWADDR;
                w_pend  = WVALID && !WREADY;   w_hold  = {WSTRB, WDATA};
                ar_pend = ARVALID && !ARREADY; ar_hold = ARADDR;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1, want 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_write", rsp_write, e.write);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                end
                last_rsp_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    // acc returns the cycle in which cmd_valid&cmd_ready was seen.
    task automatic send(input logic w, input logic [10:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] er, input logic [31:0] erd,
                        output int acc);
        int n;
        rsp_t e;
        n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got cmd_ready=0 for 100 cycles, want 1");
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        tick();
        acc = cyc - 1;
        cmd_valid = 1'b0;
        e.write = w; e.resp = er; e.rdata = erd;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || !cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got %0d responses pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int acc, acc2;
        vecs[0] = '{1'b1, 11'h0A0, 32'hDEADBEEF, 4'hF, 0, 0, 0, RESP_OKAY,   32'h0,        11'h0A0, 32'h0,        3};
        vecs[1] = '{1'b0, 11'h104, 32'h0,        4'h0, 0, 0, 5, RESP_SLVERR, 32'h12345678, 11'h104, 32'h12345678, 8};
        vecs[2] = '{1'b0, 11'h103, 32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'hA5A50001, 11'h100, 32'hA5A50001, 3};
        vecs[3] = '{1'b1, 11'h7FF, 32'h01234567, 4'h3, 2, 0, 0, RESP_DECERR, 32'h0,        11'h7FC, 32'h0,        -1};
        vecs[4] = '{1'b1, 11'h010, 32'hCAFEF00D, 4'hC, 0, 3, 2, RESP_SLVERR, 32'h0,        11'h010, 32'h0,        -1};
        vecs[5] = '{1'b0, 11'h7FE, 32'h0,        4'h0, 3, 0, 0, RESP_DECERR, 32'hFFFFFFFF, 11'h7FC, 32'hFFFFFFFF, -1};
        vecs[6] = '{1'b1, 11'h200, 32'h0,        4'h0, 1, 1, 1, RESP_OKAY,   32'h0,        11'h200, 32'h0,        -1};

        // reset state
        RESETN = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, timeout_err}, 8'h00);
        check("rst_addr", {AWADDR, ARADDR}, 22'h0);
        check("rst_data", {WDATA, WSTRB, rsp_resp}, 38'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        RESETN = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            aw_lat = vecs[i].la; ar_lat = vecs[i].la; w_lat = vecs[i].lw;
            b_lat  = vecs[i].lr; r_lat  = vecs[i].lr;
            b_resp = vecs[i].resp; r_resp = vecs[i].resp; r_data = vecs[i].rdata;
            send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].resp, vecs[i].exp_rdata, acc);
            if (vecs[i].write) begin
                check("aw_w_issue", {AWVALID, WVALID, ARVALID}, 3'b110);
                check("awaddr", AWADDR, vecs[i].exp_addr);
                check("wdata_wstrb", {WDATA, WSTRB}, {vecs[i].wdata, vecs[i].strb});
            end else begin
                check("ar_issue", {AWVALID, WVALID, ARVALID}, 3'b001);
                check("araddr", ARADDR, vecs[i].exp_addr);
            end
            check("cmd_ready_busy", cmd_ready, 1'b0);
            wait_idle();
            if (vecs[i].exp_lat >= 0) check("latency", last_rsp_cyc - acc, vecs[i].exp_lat);
            check("rdata_held", {rsp_rdata, rsp_resp}, {vecs[i].exp_rdata, vecs[i].resp});
        end

        // AW accepted three cycles before W: AWVALID drops first, WVALID held
        aw_lat = 0; w_lat = 3; b_lat = 0; b_resp = RESP_OKAY;
        send(1'b1, 11'h044, 32'h11223344, 4'hF, RESP_OKAY, 32'h0, acc);
        tick();
        check("aw_drop_first", {AWVALID, WVALID}, 2'b01);
        tick();
        check("w_still_held", {AWVALID, WVALID, BREADY}, 3'b010);
        wait_idle();
        w_lat = 0;

        // back-to-back: second command accepted in the rsp_valid cycle
        r_data = 32'h0BADF00D; r_resp = RESP_OKAY;
        send(1'b1, 11'h300, 32'h55AA55AA, 4'hF, RESP_OKAY, 32'h0, acc);
        send(1'b0, 11'h304, 32'h0, 4'h0, RESP_OKAY, 32'h0BADF00D, acc2);
        check("b2b_accept_on_rsp", acc2 - last_rsp_cyc, 0);
        check("b2b_spacing", acc2 - acc, 3);
        wait_idle();

        // stray BVALID/RVALID while idle must be ignored
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stray_ready", {BREADY, RREADY, rsp_valid, cmd_ready}, 4'b0001);
        end
        stray = 1'b0;
        tick();

        // reset while WVALID is pending
        w_lat = 10;
        send(1'b1, 11'h080, 32'hFEEDFACE, 4'hF, RESP_OKAY, 32'h0, acc);
        tick();
        check("pre_rst_wvalid", WVALID, 1'b1);
        RESETN = 1'b0;
        tick();
        exp_q.delete();
        check("midrst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'h00);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        RESETN = 1'b1;
        w_lat = 0;
        tick();
        send(1'b1, 11'h084, 32'h00000001, 4'h1, RESP_OKAY, 32'h0, acc);
        wait_idle();

        // slow B response: watchdog fires only when compiled in; response still arrives
        b_lat = 20; b_resp = RESP_OKAY;
        send(1'b1, 11'h0C0, 32'h0000ABCD, 4'hF, RESP_OKAY, 32'h0, acc);
        check("to_clear_at_start", timeout_err, 1'b0);
        wait_idle();
        check("to_flag", timeout_err, TO_EN);
        b_lat = 0; r_data = 32'h00000042; r_resp = RESP_OKAY;
        send(1'b0, 11'h0C4, 32'h0, 4'h0, RESP_OKAY, 32'h00000042, acc);
        check("to_clear_on_accept", timeout_err, 1'b0);
        wait_idle();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
